// File: rtl/frame_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : frame_stream_mux
// Description : Frame-granular N:1 stream multiplexer. Presents per-port valid
//               to an external round-robin arbiter (lock mode), latches the
//               grant and forwards the whole frame of the granted port through
//               a 2-entry registered skid buffer. The next grant is taken
//               only after the last beat of the current frame is accepted.
//               Optional macro FRAME_MUX_IFG_EN inserts an inter-frame gap of
//               IFG_CYCLES idle cycles after each frame has fully drained.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_mux #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LOG_PORTS  = $clog2(NUM_PORTS),
    parameter int IFG_CYCLES = 12
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_PORTS-1:0]            s_last,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [NUM_PORTS-1:0]            arb_requests,
    output logic                            arb_enable,
    input  logic [NUM_PORTS-1:0]            arb_onehot,
    input  logic                            arb_valid,
    output logic                            m_valid,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_last,
    input  logic                            m_ready,
    output logic [LOG_PORTS-1:0]            sel_index,
    output logic                            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1
`ifdef FRAME_MUX_IFG_EN
        ,
        S_GAP  = 2'd2
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LOG_PORTS-1:0]   r_sel_index;
    logic [LOG_PORTS-1:0]   w_grant_index;

    // Output head register (drives m_*) and one skid entry behind it
    logic                   r_m_valid;
    logic [DATA_WIDTH-1:0]  r_m_data;
    logic                   r_m_last;
    logic                   r_sk_valid;
    logic [DATA_WIDTH-1:0]  r_sk_data;
    logic                   r_sk_last;

    logic [DATA_WIDTH-1:0]  w_port_data [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_free;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_buf_empty;

    // Split the flat data bus into per-port beats
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_port_data[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_sel_data  = w_port_data[r_sel_index];
    assign w_sel_valid = s_valid[r_sel_index];
    assign w_sel_last  = s_last[r_sel_index];

    // Free space depends only on registered occupancy, never on m_ready
    assign w_free      = !(r_m_valid && r_sk_valid);
    assign w_push      = (r_state == S_PASS) && w_sel_valid && w_free;
    assign w_pop       = r_m_valid && m_ready;
    assign w_buf_empty = !r_m_valid && !r_sk_valid;

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign sel_index = r_sel_index;
    assign busy      = (r_state != S_IDLE);

    // Grant index: lowest set bit of the arbiter grant vector
    always_comb begin
        w_grant_index = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (arb_onehot[i]) begin
                w_grant_index = LOG_PORTS'(i);
            end
        end
    end

`ifdef FRAME_MUX_IFG_EN
    localparam int c_IFG_W_RAW = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);
    localparam int c_IFG_W     = (c_IFG_W_RAW < 4)  ? 4 :
                                 (c_IFG_W_RAW > 16) ? 16 : c_IFG_W_RAW;
    localparam logic [c_IFG_W-1:0] c_IFG_LOAD = c_IFG_W'(IFG_CYCLES);

    logic [c_IFG_W-1:0] r_ifg_cnt;

    // Inter-frame gap counter: loaded on frame end, counts once output drained
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifg_cnt <= '0;
        end else if (r_state == S_PASS && w_next_state == S_GAP) begin
            r_ifg_cnt <= c_IFG_LOAD;
        end else if (r_state == S_GAP && w_buf_empty && r_ifg_cnt != '0) begin
            r_ifg_cnt <= r_ifg_cnt - 1'b1;
        end
    end
`endif

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        s_ready      = '0;
        arb_requests = '0;
        arb_enable   = 1'b0;
        case (r_state)
            S_IDLE: begin
                arb_requests = s_valid;
                if (arb_valid) begin
                    // Gated so no pointer advance is signalled while held in reset
                    arb_enable   = reset_n;
                    w_next_state = S_PASS;
                end
            end
            S_PASS: begin
                s_ready[r_sel_index] = w_free;
                if (w_push && w_sel_last) begin
`ifdef FRAME_MUX_IFG_EN
                    w_next_state = S_GAP;
`else
                    w_next_state = S_IDLE;
`endif
                end
            end
`ifdef FRAME_MUX_IFG_EN
            S_GAP: begin
                if (w_buf_empty && r_ifg_cnt == '0) begin
                    w_next_state = S_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and frame owner latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_sel_index <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && arb_valid) begin
                r_sel_index <= w_grant_index;
            end
        end
    end

    // Two-entry skid buffer: head feeds m_*, skid entry refills head on pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_last  <= 1'b0;
        end else if (w_pop) begin
            if (r_sk_valid) begin
                // Buffer was full, so no push can coincide with this pop
                r_m_data   <= r_sk_data;
                r_m_last   <= r_sk_last;
                r_m_valid  <= 1'b1;
                r_sk_valid <= 1'b0;
            end else if (w_push) begin
                r_m_data  <= w_sel_data;
                r_m_last  <= w_sel_last;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_m_valid) begin
                r_m_data  <= w_sel_data;
                r_m_last  <= w_sel_last;
                r_m_valid <= 1'b1;
            end else begin
                r_sk_data  <= w_sel_data;
                r_sk_last  <= w_sel_last;
                r_sk_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
